// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery adder sequencer.
package mont_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOOP,
    ST_SUM,
    ST_SUB,
    ST_DONE
  } state_t;

  // mpadder chunk-select codes; bit 3 set holds every chunk register
  localparam logic [3:0] PH_C0   = 4'd0;
  localparam logic [3:0] PH_C1   = 4'd1;
  localparam logic [3:0] PH_C2   = 4'd2;
  localparam logic [3:0] PH_C3   = 4'd3;
  localparam logic [3:0] PH_C4   = 4'd4;
  localparam logic [3:0] PH_C5   = 4'd5;
  localparam logic [3:0] PH_IDLE = 4'd8;

  // Default operation sizing
  localparam int A_WIDTH                = 512;
  localparam int N_ITER_DEFAULT         = 256;
  localparam int MAX_SUB_PASSES_DEFAULT = 4;

endpackage

// File: rtl/mont_digit_shreg.sv
// Operand A holding register: loads a full operand, then shifts right by one
// 2-bit digit per iteration so the current digit is always in the low slot.
module mont_digit_shreg #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d_in,
  output logic [1:0]       digit
);

  localparam int N_DIG = WIDTH / 2;

  logic [WIDTH-1:0] a_shreg;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIG; gi++) begin : g_slot
      // Each 2-bit slot loads its own operand digit or takes the slot above it
      if (gi == N_DIG - 1) begin : g_top
        // Top slot fills with zeros as the operand drains out
        always_ff @(posedge clk) begin
          if (!resetn)
            a_shreg[2*gi +: 2] <= 2'b00;
          else if (load)
            a_shreg[2*gi +: 2] <= d_in[2*gi +: 2];
          else if (shift)
            a_shreg[2*gi +: 2] <= 2'b00;
        end
      end else begin : g_mid
        // Inner slots take the next-higher digit on each shift
        always_ff @(posedge clk) begin
          if (!resetn)
            a_shreg[2*gi +: 2] <= 2'b00;
          else if (load)
            a_shreg[2*gi +: 2] <= d_in[2*gi +: 2];
          else if (shift)
            a_shreg[2*gi +: 2] <= a_shreg[2*gi+2 +: 2];
        end
      end
    end
  endgenerate

  assign digit = a_shreg[1:0];

endmodule

// File: rtl/mont_adder_seq.sv
// Sequencer for the carry-save Montgomery adder: clear, N_ITER double-shift
// iterations, one carry-propagate pass, then conditional-subtract passes until
// the adder reports underflow (or the pass budget runs out).
module mont_adder_seq
  import mont_pkg::*;
#(
  parameter int N_ITER         = N_ITER_DEFAULT,
  parameter int MAX_SUB_PASSES = MAX_SUB_PASSES_DEFAULT
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] a_in,
  input  logic         subtract_finished,
  output logic         adder_resetn,
  output logic         c_doubleshift,
  output logic         subtract,
  output logic [3:0]   phase,
  output logic [1:0]   a_digit,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int PW = (MAX_SUB_PASSES > 0) ? $clog2(MAX_SUB_PASSES + 1) : 1;
  localparam logic [IW-1:0] ITER_LAST = IW'(N_ITER - 1);
  localparam logic [PW-1:0] PASS_MAX  = PW'(MAX_SUB_PASSES);

  state_t        state_reg;
  logic [IW-1:0] iter_cnt_reg;
  logic [PW-1:0] pass_cnt_reg;
  logic [PW-1:0] pass_cnt_next;
  logic          load_a;
  logic          shift_a;

  assign pass_cnt_next = pass_cnt_reg + 1'b1;

  // Operand is captured only on an accepted start and advanced once per iteration
  assign load_a  = (state_reg == ST_IDLE) && start && !abort;
  assign shift_a = (state_reg == ST_LOOP) && !abort;

  mont_digit_shreg #(
    .WIDTH (A_WIDTH)
  ) u_digit_shreg (
    .clk    (clk),
    .resetn (resetn),
    .load   (load_a),
    .shift  (shift_a),
    .d_in   (a_in),
    .digit  (a_digit)
  );

  // Main sequencer: state, counters and all registered adder controls
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      iter_cnt_reg  <= '0;
      pass_cnt_reg  <= '0;
      adder_resetn  <= 1'b0;
      c_doubleshift <= 1'b0;
      subtract      <= 1'b0;
      phase         <= PH_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else if (abort) begin
      // Drop the operation immediately; err keeps whatever it held
      state_reg     <= ST_IDLE;
      adder_resetn  <= 1'b1;
      c_doubleshift <= 1'b0;
      subtract      <= 1'b0;
      phase         <= PH_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done         <= 1'b0;
          adder_resetn <= 1'b1;
          if (start) begin
            state_reg    <= ST_CLEAR;
            adder_resetn <= 1'b0;
            busy         <= 1'b1;
            err          <= 1'b0;
            pass_cnt_reg <= '0;
            iter_cnt_reg <= '0;
          end
        end

        ST_CLEAR: begin
          adder_resetn  <= 1'b1;
          c_doubleshift <= 1'b1;
          iter_cnt_reg  <= '0;
          state_reg     <= ST_LOOP;
        end

        ST_LOOP: begin
          if (iter_cnt_reg == ITER_LAST) begin
            c_doubleshift <= 1'b0;
            subtract      <= 1'b0;
            phase         <= PH_C0;
            state_reg     <= ST_SUM;
          end else begin
            iter_cnt_reg <= iter_cnt_reg + 1'b1;
          end
        end

        ST_SUM: begin
          if (phase == PH_C5) begin
            phase     <= PH_C0;
            subtract  <= 1'b1;
            state_reg <= ST_SUB;
          end else begin
            phase <= phase + 4'd1;
          end
        end

        ST_SUB: begin
          if (phase == PH_C5) begin
            if (subtract_finished) begin
              // Underflow: c_regb already holds the last non-negative result
              subtract  <= 1'b0;
              phase     <= PH_IDLE;
              done      <= 1'b1;
              state_reg <= ST_DONE;
            end else begin
              pass_cnt_reg <= pass_cnt_next;
              if (pass_cnt_next == PASS_MAX) begin
                subtract  <= 1'b0;
                phase     <= PH_IDLE;
                done      <= 1'b1;
                err       <= 1'b1;
                state_reg <= ST_DONE;
              end else begin
                // Back-to-back pass, no idle gap
                phase <= PH_C0;
              end
            end
          end else begin
            phase <= phase + 4'd1;
          end
        end

        ST_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg     <= ST_IDLE;
          adder_resetn  <= 1'b1;
          c_doubleshift <= 1'b0;
          subtract      <= 1'b0;
          phase         <= PH_IDLE;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_adder_seq.sv
// Bench for mont_adder_seq: per-cycle expected control trace built from the
// operation rules (clear, iterations, sum pass, subtract passes, done).
module tb_mont_adder_seq;
  import mont_pkg::*;

  localparam int N    = 4;
  localparam int MAXP = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic         abort;
  logic [511:0] a_in;
  logic         subtract_finished;
  logic         adder_resetn;
  logic         c_doubleshift;
  logic         subtract;
  logic [3:0]   phase;
  logic [1:0]   a_digit;
  logic         busy;
  logic         done;
  logic         err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_done_cyc = -1;
  logic err_m = 1'b0;

  always #5 clk = ~clk;

  mont_adder_seq #(
    .N_ITER         (N),
    .MAX_SUB_PASSES (MAXP)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .start             (start),
    .abort             (abort),
    .a_in              (a_in),
    .subtract_finished (subtract_finished),
    .adder_resetn      (adder_resetn),
    .c_doubleshift     (c_doubleshift),
    .subtract          (subtract),
    .phase             (phase),
    .a_digit           (a_digit),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {adder_resetn, c_doubleshift, subtract, phase, busy, done, err}
  function automatic logic [9:0] mk(input logic ar, input logic cd, input logic sb,
                                    input int ph, input logic bs, input logic dn, input logic er);
    return {ar, cd, sb, 4'(ph), bs, dn, er};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Check this cycle's outputs, drive this cycle's inputs, advance one clock
  task automatic step(input string tag, input logic rn, input logic st, input logic ab,
                      input logic sf, input logic [9:0] exp);
    check_val(tag, {54'd0, adder_resetn, c_doubleshift, subtract, phase, busy, done, err},
              {54'd0, exp});
    if (done === 1'b1) last_done_cyc = cyc;
    resetn = rn;
    start = st;
    abort = ab;
    subtract_finished = sf;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One operation: n_rej = number of subtract passes without underflow before
  // it is reported (>= MAXP means never). abort_iter >= 0 aborts in that
  // iteration; rst_in_sub pulses resetn in the first subtract pass.
  task automatic run_op(input logic [511:0] A, input int n_rej, input int abort_iter,
                        input bit rst_in_sub);
    int cs;
    int pass;
    int npass;
    bit fin;
    logic sf;
    a_in = A;
    cs = cyc;
    last_done_cyc = -1;
    step("idle_start", 1, 1, 0, rb(), mk(1, 0, 0, 8, 0, 0, err_m));
    err_m = 1'b0;
    step("clear", 1, rb(), 0, rb(), mk(0, 0, 0, 8, 1, 0, 0));
    for (int k = 0; k < N; k++) begin
      check_val("digit", {62'd0, a_digit}, {62'd0, A[2*k +: 2]});
      if (k == abort_iter) begin
        step("loop_abort", 1, 0, 1, 0, mk(1, 1, 0, 8, 1, 0, 0));
        step("after_abort", 1, 0, 0, 0, mk(1, 0, 0, 8, 0, 0, err_m));
        step("abort_idle", 1, 0, 0, rb(), mk(1, 0, 0, 8, 0, 0, err_m));
        $display("op A=%h rej=%0d abort_iter=%0d aborted", A[15:0], n_rej, abort_iter);
        return;
      end
      step("loop", 1, rb(), 0, rb(), mk(1, 1, 0, 8, 1, 0, 0));
    end
    for (int p = 0; p < 6; p++)
      step("sum", 1, 1, 0, rb(), mk(1, 0, 0, p, 1, 0, 0));
    pass = 0;
    npass = 0;
    fin = 0;
    while (!fin) begin
      npass++;
      for (int p = 0; p < 6; p++) begin
        if (rst_in_sub && p == 3) begin
          step("sub_rst", 0, 0, 0, 0, mk(1, 0, 1, p, 1, 0, 0));
          check_val("rst_digit", {62'd0, a_digit}, 64'd0);
          step("post_rst", 1, 0, 0, 0, mk(0, 0, 0, 8, 0, 0, 0));
          err_m = 1'b0;
          $display("op A=%h reset during subtract pass", A[15:0]);
          return;
        end
        sf = (p == 5) ? (pass == n_rej) : rb();
        step("sub", 1, rb(), 0, sf, mk(1, 0, 1, p, 1, 0, 0));
        if (p == 5) begin
          if (pass == n_rej) fin = 1;
          else begin
            pass++;
            if (pass == MAXP) begin
              err_m = 1'b1;
              fin = 1;
            end
          end
        end
      end
    end
    step("done", 1, rb(), 0, rb(), mk(1, 0, 0, 8, 1, 1, err_m));
    check_val("latency", 64'(last_done_cyc - cs), 64'(1 + N + 6 + 6 * npass + 1));
    step("idle_after", 1, 0, 0, rb(), mk(1, 0, 0, 8, 0, 0, err_m));
    $display("op A=%h rej=%0d passes=%0d latency=%0d err=%0d", A[15:0], n_rej, npass,
             last_done_cyc - cs, err_m);
  endtask

  function automatic logic [511:0] rand_a();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [511:0] a;
    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    subtract_finished = 1'b0;
    a_in = '0;
    @(posedge clk);
    #1;
    cyc++;
    check_val("reset_digit", {62'd0, a_digit}, 64'd0);
    step("reset", 0, 1, 0, 0, mk(0, 0, 0, 8, 0, 0, 0));
    step("reset_hold", 1, 0, 0, 0, mk(0, 0, 0, 8, 0, 0, 0));
    step("idle_first", 1, 1, 1, 0, mk(1, 0, 0, 8, 0, 0, 0));
    step("start_abort_idle", 1, 0, 0, 0, mk(1, 0, 0, 8, 0, 0, 0));

    a = rand_a();
    a[7:0] = 8'hE4;
    run_op(a, 0, -1, 0);            // one pass, 18 cycles
    run_op(rand_a(), 2, -1, 0);     // three passes, 30 cycles
    run_op(rand_a(), MAXP - 1, -1, 0); // underflow on the last allowed pass
    run_op(rand_a(), MAXP, -1, 0);  // budget exhausted, err set
    step("err_held", 1, 0, 0, 0, mk(1, 0, 0, 8, 0, 0, 1));
    run_op(rand_a(), 0, 2, 0);      // abort in iteration 2
    run_op(rand_a(), 0, -1, 0);     // clean run after abort
    run_op(rand_a(), 1, -1, 1);     // reset inside a subtract pass
    for (int i = 0; i < 10; i++)
      run_op(rand_a(), $urandom_range(0, MAXP),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
